// File: rtl/fifo_wr_arbiter_if.sv
// Write-side bundle between the requesters, the round-robin arbiter and the FIFO write port.
// The master modport is the arbiter; the slave modport is the requester/FIFO side.
interface fifo_wr_arbiter_if #(
    parameter int NREQ  = 4,
    parameter int DSIZE = 8,
    parameter int IDW   = (NREQ > 1) ? $clog2(NREQ) : 1
);
    logic [NREQ-1:0]       req_valid;
    logic [NREQ-1:0]       req_last;
    logic [NREQ*DSIZE-1:0] req_data;
    logic [NREQ-1:0]       req_ready;
    logic                  wfull;
    logic                  winc;
    logic [DSIZE-1:0]      wdata;
    logic [NREQ-1:0]       grant;
    logic [IDW-1:0]        grant_id;

    modport master (
        input  req_valid, req_last, req_data, wfull,
        output req_ready, winc, wdata, grant, grant_id
    );

    modport slave (
        output req_valid, req_last, req_data, wfull,
        input  req_ready, winc, wdata, grant, grant_id
    );
endinterface

// File: rtl/fifo_wr_arbiter.sv
// Round-robin arbiter sharing one async-FIFO write port among NREQ requesters.
// A grant lasts up to BURST_MAX words, ending early on req_last or after TIMEOUT idle cycles.
module fifo_wr_arbiter #(
    parameter int NREQ      = 4,
    parameter int DSIZE     = 8,
    parameter int BURST_MAX = 4,
    parameter int TIMEOUT   = 8,
    parameter int IDW       = (NREQ > 1) ? $clog2(NREQ) : 1
) (
    input logic              wclk,
    input logic              wrst,
    fifo_wr_arbiter_if.master bus
);
    localparam int BW = (BURST_MAX > 1) ? $clog2(BURST_MAX) : 1;
    localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [BW-1:0]  BURST_LAST = BW'(BURST_MAX - 1);
    localparam logic [TW-1:0]  IDLE_LAST  = TW'(TIMEOUT - 1);
    localparam logic [IDW-1:0] ID_LAST    = IDW'(NREQ - 1);

    typedef enum logic {IDLE, GRANT} state_t;

    state_t          state_q;
    logic [NREQ-1:0] grant_q;
    logic [IDW-1:0]  grantId_q;
    logic [IDW-1:0]  rrPtr_q;
    logic [BW-1:0]   burstCnt_q;
    logic [TW-1:0]   idleCnt_q;

    logic [IDW-1:0]   selId_d;
    logic             selFound_d;
    logic [IDW-1:0]   hiId;
    logic             hiFound;
    logic             ownValid;
    logic             ownLast;
    logic [DSIZE-1:0] ownData;
    logic [NREQ-1:0]  readyVec;
    logic             xfer;
    logic             doRelease;

    // Lowest valid index at or above rrPtr wins; otherwise wrap to the lowest valid index overall.
    always_comb begin
        hiId       = '0;
        hiFound    = 1'b0;
        selId_d    = '0;
        selFound_d = 1'b0;
        for (int j = NREQ - 1; j >= 0; j--) begin
            if (bus.req_valid[j]) begin
                if (IDW'(j) >= rrPtr_q) begin
                    hiFound = 1'b1;
                    hiId    = IDW'(j);
                end
                selFound_d = 1'b1;
                selId_d    = IDW'(j);
            end
        end
        if (hiFound) begin
            selId_d = hiId;
        end
    end

    always_comb begin
        ownValid = 1'b0;
        ownLast  = 1'b0;
        ownData  = '0;
        readyVec = '0;
        for (int j = 0; j < NREQ; j++) begin
            if (grantId_q == IDW'(j)) begin
                ownValid = bus.req_valid[j];
                ownLast  = bus.req_last[j];
                ownData  = bus.req_data[j*DSIZE +: DSIZE];
            end
        end
        xfer = (state_q == GRANT) && ownValid && !bus.wfull;
        for (int j = 0; j < NREQ; j++) begin
            readyVec[j] = xfer && (grantId_q == IDW'(j));
        end
        // A wfull stall is neither a transfer nor an idle cycle, so it can never end the grant.
        doRelease = (state_q == GRANT) &&
                    ((xfer && (ownLast || burstCnt_q == BURST_LAST)) ||
                     (!ownValid && idleCnt_q == IDLE_LAST));
    end

    assign bus.winc      = xfer;
    assign bus.wdata     = (state_q == GRANT) ? ownData : '0;
    assign bus.req_ready = readyVec;
    assign bus.grant     = grant_q;
    assign bus.grant_id  = grantId_q;

    always_ff @(posedge wclk) begin
        if (!wrst) begin
            state_q    <= IDLE;
            grant_q    <= '0;
            grantId_q  <= '0;
            rrPtr_q    <= '0;
            burstCnt_q <= '0;
            idleCnt_q  <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (selFound_d) begin
                        state_q    <= GRANT;
                        grant_q    <= NREQ'(1) << selId_d;
                        grantId_q  <= selId_d;
                        burstCnt_q <= '0;
                        idleCnt_q  <= '0;
                    end
                end
                GRANT: begin
                    if (doRelease) begin
                        state_q    <= IDLE;
                        grant_q    <= '0;
                        grantId_q  <= '0;
                        rrPtr_q    <= (grantId_q == ID_LAST) ? '0 : grantId_q + 1'b1;
                        burstCnt_q <= '0;
                        idleCnt_q  <= '0;
                    end else if (xfer) begin
                        burstCnt_q <= burstCnt_q + 1'b1;
                        idleCnt_q  <= '0;
                    end else if (!ownValid) begin
                        idleCnt_q  <= idleCnt_q + 1'b1;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end
endmodule

// File: doc/fifo_wr_arbiter.md
Name: fifo_wr_arbiter

Overview:
- Round-robin write-side arbiter that shares the write port of the async FIFO (wdata/winc/wfull) among NREQ requesters in the wclk domain.
- Grants one requester at a time for a burst of up to BURST_MAX words, ending early on req_last or on an idle timeout.
- Sits directly in front of the FIFO write port. winc and wdata connect straight to the FIFO; wfull comes straight from the FIFO.

Parameters:
- NREQ, 4, number of requesters (2..8)
- DSIZE, 8, data width; must equal FIFO DSIZE
- BURST_MAX, 4, maximum words written per grant (>=1)
- TIMEOUT, 8, consecutive cycles the granted requester may hold valid low before its grant is revoked (>=1)
- IDW, $clog2(NREQ), width of grant_id (derived)

Ports:
- wclk  in  1  write-domain clock; all logic is on the rising edge
- wrst  in  1  reset, synchronous, active-low
- req_valid  in  NREQ  per-requester word valid
- req_last  in  NREQ  per-requester end-of-packet; qualified by req_valid
- req_data  in  NREQ*DSIZE  requester i occupies bits [i*DSIZE +: DSIZE]
- req_ready  out  NREQ  word accepted this cycle (one-hot or zero)
- wfull  in  1  FIFO full flag
- winc  out  1  FIFO write enable
- wdata  out  DSIZE  FIFO write data
- grant  out  NREQ  registered one-hot of the current owner; zero in IDLE
- grant_id  out  IDW  index of the current owner; 0 in IDLE

Behaviour:
- Reset (wrst low at an edge) sets:
  - state=IDLE, grant=0, grant_id=0
  - rr_ptr=0 (requester 0 has highest priority first)
  - burst_cnt=0, idle_cnt=0
  - so winc=0, req_ready=0, wdata=0
- Reset asserted mid-burst aborts the burst. Any word accepted before that edge is already in the FIFO; nothing is retried.
- State IDLE:
  - If any req_valid is high, select the first valid index searching upward from rr_ptr, wrapping modulo NREQ.
  - Next cycle: state=GRANT, grant/grant_id=selection, burst_cnt=0, idle_cnt=0.
  - Arbitration costs exactly 1 cycle: first write occurs no earlier than 1 cycle after req_valid rises.
- State GRANT:
  - xfer = req_valid[grant_id] & ~wfull.
  - Combinational outputs: winc=xfer; req_ready[grant_id]=xfer, all other bits 0; wdata=req_data slice of grant_id.
  - In IDLE, wdata=0.
- On xfer, burst_cnt increments and idle_cnt clears.
- Release (go to IDLE, rr_ptr=(grant_id+1) mod NREQ, grant=0) after the edge on which any of these holds:
  - xfer with req_last[grant_id]=1
  - xfer with burst_cnt==BURST_MAX-1
  - idle_cnt reaches TIMEOUT-1 while req_valid[grant_id]=0
- Timeout counting:
  - Cycles with req_valid[grant_id]=0 increment idle_cnt.
  - Cycles stalled by wfull (valid=1, wfull=1) hold idle_cnt and burst_cnt unchanged. wfull never causes release.
- After release, IDLE always spends one cycle before the next grant, even with requests pending. Maximum throughput is therefore BURST_MAX words per BURST_MAX+1 cycles.
- Non-granted requesters see req_ready=0 and must hold data/valid.
- Counter widths: burst_cnt wide enough for BURST_MAX-1; idle_cnt wide enough for TIMEOUT-1. No wrap is possible because release occurs first.
- req_last without valid is ignored. req_last together with burst_cnt==BURST_MAX-1 causes a single release.
- NREQ=1 degenerates to a burst-limited pass-through with the IDLE gap.

Test Plan:
- Reset: assert wrst=0 for 2 cycles with all req_valid=1 -> winc=0, grant=0, req_ready=0 throughout; first grant goes to requester 0, 1 cycle after wrst rises.
- Round-robin fairness: all 4 requesters valid continuously, wfull=0, no req_last, BURST_MAX=4 -> grant order 0,1,2,3,0; each grant writes exactly 4 words; 1 idle cycle between grants; wdata matches the granted slice.
- Burst split / early last: requester 2 alone sends 6 words with req_last on word 6 -> words 1-4 in grant 1, IDLE cycle, words 5-6 in grant 2, then release. Separately, a 2-word packet with last -> release after word 2.
- wfull stall: mid-burst, hold wfull=1 for 5 cycles with valid=1 -> winc=0 and req_ready=0 for those 5 cycles; no release; burst_cnt frozen; burst completes with 4 total words and no duplicates or losses (compare FIFO contents).
- Timeout: granted requester drops valid after 1 word, others valid -> release after exactly 8 idle cycles; next grant goes to grant_id+1. If valid returns on idle cycle 7, idle_cnt clears and the burst continues.
- Reset mid-burst: wrst=0 after word 2 of 4 -> next cycle grant=0, rr_ptr=0; exactly 2 words were written.
